// File: rtl/mips_bus_pkg.sv
// Shared definitions for the data-side sram-like bridge: FSM encoding,
// access-size codes and the kseg0/kseg1 physical-address mask.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } dbr_state_e;

  localparam logic [1:0]  SIZE_BYTE = 2'b00;
  localparam logic [1:0]  SIZE_HALF = 2'b01;
  localparam logic [1:0]  SIZE_WORD = 2'b10;
  localparam logic [31:0] KSEG_MASK = 32'h1FFF_FFFF;

  function automatic logic is_kseg01(input logic [31:0] a);
    return (a[31:29] == 3'b100) || (a[31:29] == 3'b101);
  endfunction

endpackage

// File: rtl/d_sramlike_bridge_if.sv
// CPU data port plus downstream sram-like data port. The master modport is
// the bridge's view; slave is the view of the CPU/memory environment.
interface d_sramlike_bridge_if;
  logic        cpu_data_en;
  logic [3:0]  cpu_data_wen;
  logic [31:0] cpu_data_addr;
  logic [31:0] cpu_data_wdata;
  logic [31:0] cpu_data_rdata;
  logic        cpu_longest_stall;
  logic        d_stall;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_addr_ok;
  logic        data_data_ok;

  modport master (
    input  cpu_data_en, cpu_data_wen, cpu_data_addr, cpu_data_wdata, cpu_longest_stall,
    output cpu_data_rdata, d_stall,
    output data_req, data_wr, data_size, data_wen, data_addr, data_wdata,
    input  data_rdata, data_addr_ok, data_data_ok
  );

  modport slave (
    output cpu_data_en, cpu_data_wen, cpu_data_addr, cpu_data_wdata, cpu_longest_stall,
    input  cpu_data_rdata, d_stall,
    input  data_req, data_wr, data_size, data_wen, data_addr, data_wdata,
    output data_rdata, data_addr_ok, data_data_ok
  );
endinterface

// File: rtl/d_bridge_size_enc.sv
// Byte-enable to sram-like access size. Anything not a single byte or an
// aligned halfword (reads and illegal masks included) is issued as a word.
module d_bridge_size_enc
  import mips_bus_pkg::*;
(
  input  logic [3:0] wen,
  output logic [1:0] size
);
  always_comb begin
    size = SIZE_WORD;
    case (wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_BYTE;
      4'b0011, 4'b1100:                   size = SIZE_HALF;
      default:                            size = SIZE_WORD;
    endcase
  end
endmodule

// File: rtl/d_sramlike_bridge.sv
// CPU memory-stage to sram-like data port bridge. Define DBRIDGE_KSEG_MAP_EN
// to fold kseg0/kseg1 addresses onto physical addresses.
module d_sramlike_bridge
  import mips_bus_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  d_sramlike_bridge_if.master   bus
);
  dbr_state_e  state;
  logic [31:0] rdata_q;
  logic        issuing;

  // A request is on the bus in REQ, or in IDLE as soon as the CPU asks.
  assign issuing = (state == ST_REQ) || ((state == ST_IDLE) && bus.cpu_data_en);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_REQ: begin
          if (issuing) begin
            if (bus.data_addr_ok && bus.data_data_ok) begin
              state   <= ST_DONE;
              rdata_q <= bus.data_rdata;
            end else if (bus.data_addr_ok) begin
              state <= ST_WAIT;
            end else begin
              state <= ST_REQ;
            end
          end
        end
        ST_WAIT: begin
          if (bus.data_data_ok) begin
            state   <= ST_DONE;
            rdata_q <= bus.data_rdata;
          end
        end
        // Holding DONE while frozen keeps the same instruction from re-issuing.
        ST_DONE: if (!bus.cpu_longest_stall) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cpu_data_rdata = rdata_q;
  assign bus.d_stall        = bus.cpu_data_en && (state != ST_DONE);
  assign bus.data_req       = resetn && issuing;
  assign bus.data_wr        = |bus.cpu_data_wen;
  assign bus.data_wen       = bus.cpu_data_wen;
  assign bus.data_wdata     = bus.cpu_data_wdata;

`ifdef DBRIDGE_KSEG_MAP_EN
  assign bus.data_addr = is_kseg01(bus.cpu_data_addr) ? (bus.cpu_data_addr & KSEG_MASK)
                                                      : bus.cpu_data_addr;
`else
  assign bus.data_addr = bus.cpu_data_addr;
`endif

  d_bridge_size_enc u_size_enc (
    .wen  (bus.cpu_data_wen),
    .size (bus.data_size)
  );
endmodule

// File: doc/d_sramlike_bridge.md
D_SRAMLIKE_BRIDGE -- requirements
Module: d_sramlike_bridge

Interface
REQ-001 clk  input  1  single clock, rising edge.
REQ-002 resetn  input  1  reset, asynchronous, active-low.
REQ-003 cpu_data_en  input  1  CPU memory stage requests an access this instruction.
REQ-004 cpu_data_wen  input  4  byte write enables; 4'b0000 means read.
REQ-005 cpu_data_addr  input  32  CPU access address, held stable by the CPU while d_stall is high.
REQ-006 cpu_data_wdata  input  32  store data, held stable by the CPU while d_stall is high.
REQ-007 cpu_data_rdata  output  32  registered load data returned to the CPU.
REQ-008 cpu_longest_stall  input  1  pipeline frozen for any reason; holds the current instruction.
REQ-009 d_stall  output  1  bridge requires the pipeline to stall.
REQ-010 data_req, data_wr  output  1 each  sram-like request and write flag to the downstream data port.
REQ-011 data_size  output  2; data_wen  output  4; data_addr, data_wdata  output  32 each.
REQ-012 data_rdata  input  32; data_addr_ok, data_data_ok  input  1 each.

Function
REQ-013 FSM states: IDLE, REQ (request presented, addr_ok pending), WAIT (addr accepted, data_ok pending), DONE (result held).
REQ-014 data_req = cpu_data_en in IDLE; 1 in REQ; 0 in WAIT and DONE.
REQ-015 Transitions: IDLE&en&addr_ok->WAIT; IDLE&en&!addr_ok->REQ; REQ&addr_ok->WAIT; WAIT&data_ok->DONE; DONE&!cpu_longest_stall->IDLE; otherwise hold.
REQ-016 addr_ok and data_ok in the same IDLE/REQ cycle: go directly to DONE and capture data_rdata.
REQ-017 data_ok in IDLE or DONE: ignored, no state or data change.
REQ-018 d_stall = cpu_data_en & (state != DONE), combinational.
REQ-019 DONE is held while cpu_longest_stall=1, preventing re-issue of the same instruction; it exits on the first cycle with cpu_longest_stall=0.
REQ-020 cpu_data_rdata loads data_rdata on the data_ok cycle and otherwise holds its value. For writes it also loads, and the CPU ignores it.
REQ-021 data_wr = |cpu_data_wen; data_wen = cpu_data_wen; data_wdata = cpu_data_wdata.
REQ-022 data_size: one-hot wen -> 2'b00; 4'b0011 or 4'b1100 -> 2'b01; every other wen, including 4'b0000 and illegal patterns, -> 2'b10.
REQ-023 Minimum latency: the load result is valid one cycle after data_ok, and d_stall drops in that same cycle.

Reset
REQ-024 While resetn=0: state=IDLE, cpu_data_rdata=32'h0, data_req=0.
REQ-025 Reset asserted mid-transaction aborts the transaction immediately, with no retry after release. The downstream port shares resetn.

Configuration
REQ-026 DBRIDGE_KSEG_MAP_EN defined: data_addr = cpu_data_addr[31:29] in {3'b100, 3'b101} ? {3'b000, cpu_data_addr[28:0]} : cpu_data_addr.
REQ-027 DBRIDGE_KSEG_MAP_EN undefined: data_addr = cpu_data_addr unchanged.

Structure
REQ-028 Shared package mips_bus_pkg holds the FSM state encoding (2 bits), the SIZE_BYTE/SIZE_HALF/SIZE_WORD constants, and the KSEG mask constant.
REQ-029 One sub-module, d_bridge_size_enc, implements the combinational wen-to-size mapping of REQ-022.

Verification
REQ-030 Read: en=1, wen=0, addr=32'h0000_1000; addr_ok in cycle 1; data_ok with data_rdata=32'hDEADBEEF in cycle 3 -> data_req high cycles 1..1 only, data_size=2'b10, cpu_data_rdata=32'hDEADBEEF and d_stall=0 in cycle 4.
REQ-031 Store byte: wen=4'b0100, wdata=32'h00AB0000; addr_ok delayed 3 cycles -> data_req held through the REQ state with stable outputs, data_wr=1, data_size=2'b00.
REQ-032 Same-cycle addr_ok+data_ok in IDLE -> FSM goes to DONE, rdata captured, no second request issued.
REQ-033 cpu_longest_stall=1 for 5 cycles after DONE -> d_stall=0 and data_req=0 throughout; IDLE entered on the cycle stall falls.
REQ-034 resetn pulsed low while in WAIT -> d_stall=en, state=IDLE, cpu_data_rdata=0; a late data_ok is ignored.
REQ-035 With the macro defined: addr=32'hBFC0_0000 -> data_addr=32'h1FC0_0000; addr=32'h8000_0004 -> 32'h0000_0004; addr=32'h0040_0000 is unchanged. With the macro undefined, all three pass through.
